// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: rotates one low column, assembles a
// 16-bit frame (bit = 4*column + row), debounces whole frames and holds a one-hot key code.
module keypad_scan #(
   parameter logic [15:0] SCAN_DIV   = 16'd50000,
   parameter int unsigned DEBOUNCE_N = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_n,
   output logic [3:0]  col_n,
   output logic [15:0] onehot,
   output logic        key_pressed,
   output logic        key_event
);

   localparam logic [15:0] DWELL_LAST = SCAN_DIV - 16'd1;
   localparam logic [3:0]  STABLE_MAX = 4'(DEBOUNCE_N);
   localparam logic [3:0]  STABLE_ARM = 4'(DEBOUNCE_N - 1);

   logic [3:0]  row_meta_q, row_meta_d;
   logic [3:0]  row_sync_q, row_sync_d;
   logic [15:0] dwell_q, dwell_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [3:0]  col_n_q, col_n_d;
   logic [15:0] frame_q, frame_d;
   logic [15:0] prev_q, prev_d;
   logic [3:0]  stable_q, stable_d;
   logic [15:0] onehot_q, onehot_d;
   logic        key_pressed_q, key_pressed_d;
   logic        key_event_q, key_event_d;

   logic        sample;
   logic        frame_done;
   logic        frame_same;
   logic        single_key;
   logic [3:0]  rows_pressed;
   logic [3:0]  frame_nib [4];

   assign rows_pressed = ~row_sync_q;
   assign sample       = (dwell_q == DWELL_LAST);
   assign frame_done   = sample && (col_idx_q == 2'd3);

   // Only the nibble of the column being sampled is overwritten; the rest is kept.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign frame_nib[gi] = (sample && (col_idx_q == 2'(gi)))
                                ? rows_pressed
                                : frame_q[4*gi +: 4];
      end
   endgenerate

   assign frame_same = (frame_d == prev_q);
   assign single_key = (frame_d != 16'h0) && ((frame_d & (frame_d - 16'h1)) == 16'h0);

   always_comb begin
      row_meta_d    = row_n;
      row_sync_d    = row_meta_q;
      dwell_d       = dwell_q + 16'd1;
      col_idx_d     = col_idx_q;
      col_n_d       = col_n_q;
      frame_d       = {frame_nib[3], frame_nib[2], frame_nib[1], frame_nib[0]};
      prev_d        = prev_q;
      stable_d      = stable_q;
      onehot_d      = onehot_q;
      key_event_d   = 1'b0;

      if (sample) begin
         dwell_d   = 16'd0;
         col_idx_d = col_idx_q + 2'd1;
         col_n_d   = {col_n_q[2:0], col_n_q[3]};
      end

      if (frame_done) begin
         prev_d = frame_d;
         if (frame_same) begin
            stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + 4'd1;
            // Update only on the arming transition, never while already saturated.
            if (stable_q == STABLE_ARM) begin
               onehot_d    = single_key ? frame_d : 16'h0;
               key_event_d = single_key && (frame_d != onehot_q);
            end
         end else begin
            stable_d = 4'd0;
         end
      end

      key_pressed_d = (onehot_d != 16'h0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q    <= 4'b1111;
         row_sync_q    <= 4'b1111;
         dwell_q       <= 16'd0;
         col_idx_q     <= 2'd0;
         col_n_q       <= 4'b1110;
         frame_q       <= 16'h0;
         prev_q        <= 16'h0;
         stable_q      <= 4'd0;
         onehot_q      <= 16'h0;
         key_pressed_q <= 1'b0;
         key_event_q   <= 1'b0;
      end else begin
         row_meta_q    <= row_meta_d;
         row_sync_q    <= row_sync_d;
         dwell_q       <= dwell_d;
         col_idx_q     <= col_idx_d;
         col_n_q       <= col_n_d;
         frame_q       <= frame_d;
         prev_q        <= prev_d;
         stable_q      <= stable_d;
         onehot_q      <= onehot_d;
         key_pressed_q <= key_pressed_d;
         key_event_q   <= key_event_d;
      end
   end

   assign col_n       = col_n_q;
   assign onehot      = onehot_q;
   assign key_pressed = key_pressed_q;
   assign key_event   = key_event_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad, debounces whole-matrix frames and presents a held 16-bit one-hot key code.
- Sits directly upstream of the one-hot to BCD digit encoder, which consumes onehot on every clk edge.
- Bit mapping is fixed: onehot bit index = 4*column + row. Digit keys land on bits 3,5,6,7,9,10,11,13,14,15, as the encoder expects.

Parameters:
- SCAN_DIV, 16'd50000: clk cycles each column is driven low (column dwell). Legal range >= 4.
- DEBOUNCE_N, 4: consecutive identical frames required before onehot may change. Legal range 1..15.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- row_n, input, 4: keypad rows, active-low, pulled up externally, asynchronous to clk.
- col_n, output, 4: keypad column drive, active-low, exactly one bit low at any time.
- onehot, output, 16: debounced key code. Exactly one bit set, or all zero.
- key_pressed, output, 1: high while onehot != 0.
- key_event, output, 1: one-cycle pulse when onehot changes to a new non-zero value.

Behaviour:
- Reset (rst high at a clk edge):
  - col_n=4'b1110, column index 0, dwell counter 0.
  - Frame register, previous-frame register and stable counter cleared to 0.
  - onehot=0, key_pressed=0, key_event=0.
  - The row synchronizer is cleared to 4'b1111.
  - Reset mid-scan or mid-debounce aborts everything; no output change is carried over.
- Row synchronizer: two flops on row_n. Inverted synchronized rows (1 = pressed) are used internally.
- Scan:
  - The dwell counter counts 0..SCAN_DIV-1 and wraps.
  - On the edge where it equals SCAN_DIV-1, the synchronized rows are written to frame[4*c+3:4*c] (c = current column). On the same edge, c advances modulo 4 and col_n rotates so that column c is low (col 0 -> 4'b1110, col 1 -> 4'b1101, col 2 -> 4'b1011, col 3 -> 4'b0111).
  - Frame period = 4*SCAN_DIV cycles.
- Frame complete is the sample edge of column 3. On that edge, the new frame F (including the column-3 nibble just sampled) is compared to the previous frame P:
  - If F == P, the stable counter increments, saturating at DEBOUNCE_N.
  - Otherwise the stable counter is set to 0.
  - P <= F.
- Output update: on a frame-complete edge where the stable counter becomes DEBOUNCE_N (transition from DEBOUNCE_N-1, not while saturated):
  - If popcount(F)==1, onehot <= F.
  - If popcount(F)==0 or >=2, onehot <= 0. Multi-key ghosting is rejected.
  - The new value is visible the cycle after the edge.
- onehot is held unchanged between updates. A bounce that resets the counter never glitches onehot.
- key_pressed is registered and equals (next onehot != 0), aligned with onehot.
- key_event is high for exactly one cycle, aligned with the onehot update, iff the new onehot != 0 and != the old onehot.
  - A key-to-key change without an intervening release pulses again.
  - Release (to 0) never pulses.
- Latency: a press held steady from a frame boundary appears after DEBOUNCE_N+1 complete frames, +1 cycle. Release is symmetric.
- No combinational path from row_n to any output.

Test Plan:
- Reset/idle (SCAN_DIV=4, DEBOUNCE_N=2), rows all high:
  - col_n cycles 1110,1101,1011,0111 every 4 cycles.
  - onehot=0, key_pressed=0, key_event never asserts.
  - Assert rst mid-frame: col_n=1110 the next cycle.
- Single press "5" (row 2 pulled low only while column 2 is low, i.e. bit 10), held from a frame boundary:
  - After 3 frames (48 cycles) +1, onehot=16'h0400, key_pressed=1.
  - key_event pulses one cycle. Release returns onehot to 0 after 3 frames, with no pulse.
- Bounce: toggle the bit-10 contact every frame for 5 frames, then hold:
  - onehot stays 0 throughout the bounce.
  - Updates to 16'h0400 exactly 3 frames after the hold begins.
- Two keys (bits 7 and 13) held together: onehot stays 0 and key_event never asserts. Releasing bit 13 gives 16'h0080 after 3 frames, with a pulse.
- Key change 16'h8000 -> 16'h2000 with no release gap: onehot switches directly, key_event pulses once for the new key.
- Every digit key in turn: onehot equals the expected bit (e.g. "0" -> 16'h0008, "9" -> 16'h2000).
